// File: rtl/bist_vector_engine_if.sv
// Vector load port for bist_vector_engine: valid/ready beats carrying
// stimulus, expected response, don't-care mask and end-of-set marker.
interface bist_vector_engine_if #(
    parameter int unsigned STIM_W = 5,
    parameter int unsigned RESP_W = 4
);
    logic              load_valid;
    logic              load_ready;
    logic [STIM_W-1:0] load_stim;
    logic [RESP_W-1:0] load_exp;
    logic [RESP_W-1:0] load_mask;
    logic              load_last;

    modport master (
        output load_valid, load_stim, load_exp, load_mask, load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_stim, load_exp, load_mask, load_last,
        output load_ready
    );
endinterface

// File: rtl/bist_vector_engine.sv
// RUNBIST vector engine: stores loaded vectors, replays them to the DUT and
// compares responses one cycle later. Optional mask storage: BIST_MASK_EN.
module bist_vector_engine #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned STIM_W   = 5,
    parameter int unsigned RESP_W   = 4,
    parameter int unsigned ERRCNT_W = 8,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tlr,
    bist_vector_engine_if.slave ld,
    input  logic                run,
    output logic [STIM_W-1:0]   bist_out,
    input  logic [RESP_W-1:0]   bist_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [AW-1:0]       fail_addr,
    output logic [RESP_W-1:0]   fail_data
);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       vec_cnt_q, vec_cnt_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic                ff_seen_q, ff_seen_d;
    logic [STIM_W-1:0]   bist_out_d;
    logic                busy_d, done_d, pass_d;
    logic [ERRCNT_W-1:0] err_cnt_d;
    logic [AW-1:0]       fail_addr_d;
    logic [RESP_W-1:0]   fail_data_d;

    logic [STIM_W-1:0] stim_mem [DEPTH];
    logic [RESP_W-1:0] exp_mem  [DEPTH];
    logic [RESP_W-1:0] care_c;
    logic              accept_c;
    logic              mismatch_c;

    assign ld.load_ready = (state_q == IDLE) && (wr_ptr_q < CW'(DEPTH));
    assign accept_c      = ld.load_valid && ld.load_ready;

    // Vector storage is never reset; only the set bookkeeping is.
    always_ff @(posedge clk) begin
        if (accept_c && !tlr) begin
            stim_mem[wr_ptr_q[AW-1:0]] <= ld.load_stim;
            exp_mem[wr_ptr_q[AW-1:0]]  <= ld.load_exp;
        end
    end

`ifdef BIST_MASK_EN
    logic [RESP_W-1:0] mask_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (accept_c && !tlr) begin
            mask_mem[wr_ptr_q[AW-1:0]] <= ld.load_mask;
        end
    end

    assign care_c = ~mask_mem[pc_q];
`else
    logic unused_mask;
    assign unused_mask = ^ld.load_mask;
    assign care_c      = '1;
`endif

    // bist_in holds the response to the vector currently on bist_out.
    assign mismatch_c = |((bist_in ^ exp_mem[pc_q]) & care_c);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        vec_cnt_d   = vec_cnt_q;
        pc_d        = pc_q;
        ff_seen_d   = ff_seen_q;
        bist_out_d  = bist_out;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        err_cnt_d   = err_cnt;
        fail_addr_d = fail_addr;
        fail_data_d = fail_data;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    vec_cnt_d = wr_ptr_q + CW'(1);
                    wr_ptr_d  = ld.load_last ? '0 : wr_ptr_q + CW'(1);
                end
                if (run) begin
                    wr_ptr_d    = '0;
                    pc_d        = '0;
                    ff_seen_d   = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    if (vec_cnt_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        bist_out_d = stim_mem[0];
                    end
                end
            end
            RUN: begin
                if (!run) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    bist_out_d = '0;
                end else begin
                    if (mismatch_c) begin
                        err_cnt_d = (err_cnt == '1) ? err_cnt : err_cnt + ERRCNT_W'(1);
                        if (!ff_seen_q) begin
                            ff_seen_d   = 1'b1;
                            fail_addr_d = pc_q;
                            fail_data_d = bist_in;
                        end
                    end
                    if (CW'(pc_q) == vec_cnt_q - CW'(1)) begin
                        state_d    = DONE;
                        bist_out_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        pass_d     = (err_cnt_d == '0);
                    end else begin
                        pc_d       = pc_q + AW'(1);
                        bist_out_d = stim_mem[pc_d];
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Test-Logic-Reset overrides every other update.
        if (tlr) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            vec_cnt_d   = '0;
            pc_d        = '0;
            ff_seen_d   = 1'b0;
            bist_out_d  = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_cnt_d   = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            vec_cnt_q <= '0;
            pc_q      <= '0;
            ff_seen_q <= 1'b0;
            bist_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            vec_cnt_q <= vec_cnt_d;
            pc_q      <= pc_d;
            ff_seen_q <= ff_seen_d;
            bist_out  <= bist_out_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_cnt   <= err_cnt_d;
            fail_addr <= fail_addr_d;
            fail_data <= fail_data_d;
        end
    end
endmodule

// File: tb/tb_bist_vector_engine.sv
// Randomized self-checking bench for bist_vector_engine (DEPTH=4, ERRCNT_W=2)
// against a set-level reference model of load, replay and result reporting.
module tb_bist_vector_engine;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned STIM_W   = 5;
    localparam int unsigned RESP_W   = 4;
    localparam int unsigned ERRCNT_W = 2;
    localparam int unsigned AW       = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                tlr = 1'b0;
    logic                run = 1'b0;
    logic [STIM_W-1:0]   bist_out;
    logic [RESP_W-1:0]   bist_in = '0;
    logic                busy, done, pass;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [AW-1:0]       fail_addr;
    logic [RESP_W-1:0]   fail_data;

    bist_vector_engine_if #(.STIM_W(STIM_W), .RESP_W(RESP_W)) ld_if ();

    bist_vector_engine #(
        .DEPTH(DEPTH), .STIM_W(STIM_W), .RESP_W(RESP_W), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tlr(tlr), .ld(ld_if), .run(run),
        .bist_out(bist_out), .bist_in(bist_in), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: stored set, load pointer and planned DUT responses.
    logic [STIM_W-1:0] stim_m [DEPTH];
    logic [RESP_W-1:0] exp_m  [DEPTH];
    logic [RESP_W-1:0] mask_m [DEPTH];
    logic [RESP_W-1:0] resp_m [DEPTH];
    int wp  = 0;
    int n_m = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [RESP_W-1:0] care(input int k);
`ifdef BIST_MASK_EN
        return ~mask_m[k];
`else
        return 4'hF;
`endif
    endfunction

    task automatic offer(input logic [STIM_W-1:0] s, input logic [RESP_W-1:0] e,
                         input logic [RESP_W-1:0] m, input logic last);
        logic rdy;
        @(negedge clk);
        ld_if.load_valid = 1'b1;
        ld_if.load_stim  = s;
        ld_if.load_exp   = e;
        ld_if.load_mask  = m;
        ld_if.load_last  = last;
        rdy = (wp < DEPTH);
        #1 check_eq("load_ready", 32'(ld_if.load_ready), 32'(rdy));
        @(posedge clk);
        if (rdy) begin
            stim_m[wp] = s; exp_m[wp] = e; mask_m[wp] = m;
            n_m = wp + 1;
            wp  = last ? 0 : wp + 1;
        end
    endtask

    task automatic end_load();
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        ld_if.load_last  = 1'b0;
    endtask

    task automatic loopback_resp();
        for (int k = 0; k < DEPTH; k++) resp_m[k] = stim_m[k][RESP_W-1:0];
    endtask

    // Run the stored set to completion and check every launch and the results.
    task automatic play();
        int errs = 0;
        int first = 0;
        int sat;
        for (int k = 0; k < n_m; k++) begin
            if (((resp_m[k] ^ exp_m[k]) & care(k)) != 0) begin
                if (errs == 0) first = k;
                errs++;
            end
        end
        sat = (errs > 3) ? 3 : errs;
        @(negedge clk);
        run = 1'b1;
        wp  = 0;
        for (int k = 0; k < n_m; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("bist_out[%0d]", k), 32'(bist_out), 32'(stim_m[k]));
            check_eq("busy_run", 32'(busy), 32'd1);
            check_eq("done_run", 32'(done), 32'd0);
            bist_in = resp_m[k];
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("done_final", 32'(done), 32'd1);
        check_eq("pass_final", 32'(pass), 32'(errs == 0));
        check_eq("err_cnt_final", 32'(err_cnt), 32'(sat));
        check_eq("fail_addr", 32'(fail_addr), 32'(first));
        check_eq("fail_data", 32'(fail_data), errs != 0 ? 32'(resp_m[first]) : 32'd0);
        check_eq("bist_out_done", 32'(bist_out), 32'd0);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("load_ready_done", 32'(ld_if.load_ready), 32'd0);
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("done_cleared", 32'(done), 32'd0);
        check_eq("pass_cleared", 32'(pass), 32'd0);
        check_eq("err_cnt_held", 32'(err_cnt), 32'(sat));
    endtask

    initial begin
        ld_if.load_valid = 1'b0;
        ld_if.load_stim  = '0;
        ld_if.load_exp   = '0;
        ld_if.load_mask  = '0;
        ld_if.load_last  = 1'b0;
        #1;
        check_eq("rst_bist_out", 32'(bist_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_load_ready", 32'(ld_if.load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic three-vector set with loopback responses, then one corrupted response.
        offer(5'h01, 4'h1, 4'h0, 1'b0);
        offer(5'h02, 4'h2, 4'h0, 1'b0);
        offer(5'h03, 4'h3, 4'h0, 1'b1);
        end_load();
        loopback_resp();
        play();
        resp_m[1] = 4'h0;
        play();

        // Don't-care mask on vector 1.
        offer(5'h01, 4'h1, 4'h0, 1'b0);
        offer(5'h02, 4'h2, 4'hF, 1'b0);
        offer(5'h03, 4'h3, 4'h0, 1'b1);
        end_load();
        loopback_resp();
        resp_m[1] = 4'h9;
        play();

        // Every vector mismatches: counter saturates.
        for (int k = 0; k < 4; k++) offer(5'(k + 8), 4'(k), 4'h0, k == 3);
        end_load();
        for (int k = 0; k < 4; k++) resp_m[k] = exp_m[k] ^ 4'hF;
        play();

        // Fill without load_last; the fifth beat is refused.
        for (int k = 0; k < 5; k++) offer(5'(k + 17), 4'(k + 1), 4'h0, 1'b0);
        end_load();
        loopback_resp();
        play();

        // Abort by dropping run after vector 1 launches.
        @(negedge clk);
        run = 1'b1;
        bist_in = stim_m[0][RESP_W-1:0];
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_bist_out_v1", 32'(bist_out), 32'(stim_m[1]));
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_bist_out", 32'(bist_out), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("abort_load_ready", 32'(ld_if.load_ready), 32'd1);
        wp = 0;

        // tlr mid-run, then an empty set.
        run = 1'b1;
        bist_in = 4'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tlr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tlr = 1'b0;
        run = 1'b0;
        wp = 0; n_m = 0;
        check_eq("tlr_bist_out", 32'(bist_out), 32'd0);
        check_eq("tlr_busy", 32'(busy), 32'd0);
        check_eq("tlr_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("tlr_fail_addr", 32'(fail_addr), 32'd0);
        check_eq("tlr_fail_data", 32'(fail_data), 32'd0);
        check_eq("tlr_load_ready", 32'(ld_if.load_ready), 32'd1);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("empty_done", 32'(done), 32'd1);
        check_eq("empty_pass", 32'(pass), 32'd1);
        check_eq("empty_busy", 32'(busy), 32'd0);
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("empty_done_cleared", 32'(done), 32'd0);

        // Randomized sets and responses.
        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++)
                offer(5'($urandom), 4'($urandom), 4'($urandom),
                      (k == n - 1) && (n < DEPTH || $urandom_range(0, 1) == 1));
            end_load();
            for (int k = 0; k < n; k++)
                resp_m[k] = ($urandom_range(0, 1) == 1) ? exp_m[k] : 4'($urandom);
            play();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
